mul_div_unit: RTL

- Iterative 16-bit multiply/divide execution unit. Sits directly downstream of the register file.
- Consumes the two read operands (dataRead1, dataRead2) and a destination index.
- Returns a two-part result to the register file write port:
  - low half (product low / quotient) goes to Rd through dataWrite;
  - high half (product high / remainder) goes to R0 through r0Write.
- Multi-cycle, with a busy/done handshake toward the control unit.

---
 rtl/mul_div_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 16-bit signed/unsigned multiply and divide unit.
// The low result half feeds Rd (dataWrite); the high half feeds R0 (r0Write).
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [3:0]       destIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultLow,
  output logic [WIDTH-1:0] resultHigh,
  output logic [1:0]       regWrite,
  output logic [3:0]       regWriteLocal,
  output logic             divByZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t stateReg, stateNext;

  // Operation context captured at start-accept
  logic             isDivReg;
  logic [3:0]       destReg;
  logic             negAReg, negBReg;
  logic [WIDTH-1:0] divisorReg;   // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0] prodReg;    // {high accumulator, remaining multiplier bits}
  logic [WIDTH-1:0] remReg;       // partial remainder (top bit never needed between steps)
  logic [WIDTH-1:0] quoReg;       // dividend bits shift out, quotient bits shift in
  logic [CNT_W-1:0] cntReg;

  // Next values for the registered outputs
  logic             busyNext, doneNext, dbzNext;
  logic [1:0]       regWriteNext;
  logic [WIDTH-1:0] lowNext, highNext;
  logic [3:0]       localNext;

  // Incoming operand magnitudes and sign flags (signed ops have op[0]==0)
  logic             negA, negB;
  logic [WIDTH-1:0] magA, magB;
  always_comb begin
    negA = ~op[0] & opA[WIDTH-1];
    negB = ~op[0] & opB[WIDTH-1];
    magA = negA ? -opA : opA;
    magB = negB ? -opB : opB;
  end

  // One shift-add multiply step and one restoring-divide step
  logic [WIDTH:0] mulSum, shifted, diff;
  always_comb begin
    mulSum  = {1'b0, prodReg[2*WIDTH-1:WIDTH]} +
              (prodReg[0] ? {1'b0, divisorReg} : {(WIDTH+1){1'b0}});
    shifted = {remReg, quoReg[WIDTH-1]};
    diff    = shifted - {1'b0, divisorReg};
  end

  // Sign correction of the magnitude results; division by zero overrides the quotient
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix, fixLow, fixHigh;
  logic               fixDbz;
  always_comb begin
    prodFix = (negAReg ^ negBReg) ? -prodReg : prodReg;
    quoFix  = (negAReg ^ negBReg) ? -quoReg : quoReg;
    remFix  = negAReg ? -remReg : remReg;
    fixDbz  = isDivReg && (divisorReg == '0);
    if (!isDivReg) begin
      fixLow  = prodFix[WIDTH-1:0];
      fixHigh = prodFix[2*WIDTH-1:WIDTH];
    end else begin
      fixLow  = fixDbz ? {WIDTH{1'b1}} : quoFix;
      fixHigh = remFix;   // with a zero divisor this reproduces opA exactly
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // Next-state and next-output decode
  always_comb begin
    stateNext    = stateReg;
    busyNext     = busy;
    doneNext     = 1'b0;
    regWriteNext = 2'b00;
    lowNext      = resultLow;
    highNext     = resultHigh;
    localNext    = regWriteLocal;
    dbzNext      = divByZero;
    case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext = CALC;
          busyNext  = 1'b1;
        end
      end
      CALC: begin
        if (cntReg == CNT_W'(WIDTH-1)) stateNext = FIX;
      end
      FIX: begin
        stateNext    = DONE;
        doneNext     = 1'b1;
        regWriteNext = 2'b11;
        lowNext      = fixLow;
        highNext     = fixHigh;
        localNext    = destReg;
        dbzNext      = fixDbz;
      end
      DONE: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one iteration per CALC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      isDivReg   <= 1'b0;
      destReg    <= '0;
      negAReg    <= 1'b0;
      negBReg    <= 1'b0;
      divisorReg <= '0;
      prodReg    <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      cntReg     <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            isDivReg   <= op[1];
            destReg    <= destIn;
            negAReg    <= negA;
            negBReg    <= negB;
            divisorReg <= magB;
            prodReg    <= {{WIDTH{1'b0}}, magA};
            quoReg     <= magA;
            remReg     <= '0;
            cntReg     <= '0;
          end
        end
        CALC: begin
          cntReg <= cntReg + CNT_W'(1);
          if (!isDivReg) begin
            prodReg <= {mulSum, prodReg[WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            remReg <= diff[WIDTH-1:0];
            quoReg <= {quoReg[WIDTH-2:0], 1'b1};
          end else begin
            remReg <= shifted[WIDTH-1:0];
            quoReg <= {quoReg[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      regWrite      <= 2'b00;
      resultLow     <= '0;
      resultHigh    <= '0;
      regWriteLocal <= '0;
      divByZero     <= 1'b0;
    end else begin
      busy          <= busyNext;
      done          <= doneNext;
      regWrite      <= regWriteNext;
      resultLow     <= lowNext;
      resultHigh    <= highNext;
      regWriteLocal <= localNext;
      divByZero     <= dbzNext;
    end
  end

endmodule
